// File: rtl/ram_nxm_sync.sv
// Single-port DEPTH x WIDTH synchronous RAM with a registered 1-cycle read,
// a read-valid strobe, a reject strobe, and a hardware clear sweep started by CLR.
module ram_nxm_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             CLK_,
  input  logic             CLR,
  input  logic             EN,
  input  logic             R_W_,
  input  logic [AW-1:0]    ADDR_,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             rd_valid,
  output logic             busy,
  output logic             err
);

  typedef enum logic {CLEAR, IDLE} state_t;

  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             rd_valid_q, rd_valid_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             in_range;

  // Only needed when DEPTH is not a power of two; otherwise always true.
  assign in_range = ({1'b0, ADDR_} < DEPTH_W);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    data_out_d = data_out_q;
    rd_valid_d = 1'b0;
    busy_d     = busy_q;
    err_d      = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = ADDR_;
    mem_wdata  = data_in;
    if (!CLR) begin
      case (state_q)
        CLEAR: begin
          mem_we    = 1'b1;
          mem_waddr = ptr_q;
          mem_wdata = '0;
          ptr_d     = ptr_q + AW'(1);
          err_d     = EN;
          if (ptr_q == LAST_PTR) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            ptr_d   = '0;
          end
        end
        IDLE: begin
          if (EN) begin
            if (!in_range) begin
              err_d = 1'b1;
            end else if (R_W_) begin
              mem_we = 1'b1;
            end else begin
              data_out_d = mem[ADDR_];
              rd_valid_d = 1'b1;
            end
          end
        end
        default: state_d = CLEAR;
      endcase
    end
  end

  always_ff @(posedge CLK_) begin
    if (CLR) begin
      state_q    <= CLEAR;
      ptr_q      <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  // Storage has no reset; the sweep is the only way it gets zeroed.
  always_ff @(posedge CLK_) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ram_nxm_sync.sv
// Bench for ram_nxm_sync: three instances (8x4, 8x3, 16x8) driven by directed
// vectors; a negedge monitor matches rd_valid/err pulses against a queue of expectations.
module tb_ram_nxm_sync;

  typedef struct {
    int          due;
    int          kind;
    logic [15:0] data;
  } exp_t;

  localparam int K_NONE = 0;
  localparam int K_RD   = 1;
  localparam int K_ERR  = 2;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic [2:0]  clr_v = 3'b000;
  logic [2:0]  en_v  = 3'b000;
  logic [2:0]  rw_v  = 3'b000;
  logic [2:0]  addr_v [3];
  logic [15:0] din_v  [3];

  logic [7:0]  dout0, dout1;
  logic [15:0] dout2;
  logic [15:0] dout   [3];
  logic [2:0]  rdv_v, busy_v, err_v;

  exp_t        exp_q [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_nxm_sync #(.WIDTH(8), .DEPTH(4), .AW(2)) dut0 (
    .CLK_(clk), .CLR(clr_v[0]), .EN(en_v[0]), .R_W_(rw_v[0]),
    .ADDR_(addr_v[0][1:0]), .data_in(din_v[0][7:0]), .data_out(dout0),
    .rd_valid(rdv_v[0]), .busy(busy_v[0]), .err(err_v[0])
  );

  ram_nxm_sync #(.WIDTH(8), .DEPTH(3), .AW(2)) dut1 (
    .CLK_(clk), .CLR(clr_v[1]), .EN(en_v[1]), .R_W_(rw_v[1]),
    .ADDR_(addr_v[1][1:0]), .data_in(din_v[1][7:0]), .data_out(dout1),
    .rd_valid(rdv_v[1]), .busy(busy_v[1]), .err(err_v[1])
  );

  ram_nxm_sync #(.WIDTH(16), .DEPTH(8), .AW(3)) dut2 (
    .CLK_(clk), .CLR(clr_v[2]), .EN(en_v[2]), .R_W_(rw_v[2]),
    .ADDR_(addr_v[2]), .data_in(din_v[2]), .data_out(dout2),
    .rd_valid(rdv_v[2]), .busy(busy_v[2]), .err(err_v[2])
  );

  assign dout[0] = {8'h00, dout0};
  assign dout[1] = {8'h00, dout1};
  assign dout[2] = dout2;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one instance for the coming edge and records what it must answer.
  task automatic applyStimulus(input int i, input logic clr, input logic en, input logic rw,
                               input logic [2:0] addr, input logic [15:0] din,
                               input int kind, input logic [15:0] expd);
    exp_t e;
    clr_v[i]  = clr;
    en_v[i]   = en;
    rw_v[i]   = rw;
    addr_v[i] = addr;
    din_v[i]  = din;
    if (kind != K_NONE) begin
      e.due  = cyc + 1;
      e.kind = kind;
      e.data = expd;
      exp_q[i].push_back(e);
    end
  endtask

  task automatic rd(input int i, input logic [2:0] a, input logic [15:0] expd);
    applyStimulus(i, 1'b0, 1'b1, 1'b0, a, 16'h0, K_RD, expd);
    tick();
  endtask

  task automatic wr(input int i, input logic [2:0] a, input logic [15:0] d);
    applyStimulus(i, 1'b0, 1'b1, 1'b1, a, d, K_NONE, 16'h0);
    tick();
  endtask

  task automatic bad(input int i, input logic rw, input logic [2:0] a, input logic [15:0] d);
    applyStimulus(i, 1'b0, 1'b1, rw, a, d, K_ERR, 16'h0);
    tick();
  endtask

  task automatic nop(input int i);
    applyStimulus(i, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, K_NONE, 16'h0);
    tick();
  endtask

  task automatic clr(input int i);
    applyStimulus(i, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0, K_NONE, 16'h0);
    tick();
  endtask

  // Any rd_valid or err pulse must match the oldest expectation and its cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    int   got;
    if (cyc > 0) begin
      for (int i = 0; i < 3; i++) begin
        got = {30'b0, err_v[i], rdv_v[i]};
        if (got != 0) begin
          if (exp_q[i].size() == 0) begin
            checkOutput($sformatf("unexpected_resp%0d", i), got, K_NONE);
          end else begin
            e = exp_q[i].pop_front();
            checkOutput($sformatf("resp_cycle%0d", i), cyc, e.due);
            checkOutput($sformatf("resp_kind%0d", i), got, e.kind);
            if (e.kind == K_RD) checkOutput($sformatf("rd_data%0d", i), dout[i], e.data);
          end
        end else if (exp_q[i].size() != 0 && exp_q[i][0].due <= cyc) begin
          e = exp_q[i].pop_front();
          checkOutput($sformatf("missing_resp%0d", i), got, e.kind);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      addr_v[i] = 3'd0;
      din_v[i]  = 16'h0;
    end

    // Reset all three together, then watch each sweep length.
    clr_v = 3'b111;
    tick();
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("rst_busy%0d", i), busy_v[i], 1);
      checkOutput($sformatf("rst_dout%0d", i), dout[i], 0);
      checkOutput($sformatf("rst_rdv%0d", i), rdv_v[i], 0);
      checkOutput($sformatf("rst_err%0d", i), err_v[i], 0);
    end
    tick();
    clr_v = 3'b000;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checkOutput($sformatf("sweep0_busy_e%0d", k), busy_v[0], (k < 4) ? 1 : 0);
      checkOutput($sformatf("sweep1_busy_e%0d", k), busy_v[1], (k < 3) ? 1 : 0);
      checkOutput($sformatf("sweep2_busy_e%0d", k), busy_v[2], (k < 8) ? 1 : 0);
    end

    // Cleared memory reads back zero with back-to-back reads.
    for (int a = 0; a < 4; a++) rd(0, 3'(a), 16'h0000);
    nop(0);

    // Write/read ordering and data_out hold across a write.
    wr(0, 3'd0, 16'h00A5);
    wr(0, 3'd3, 16'h003C);
    rd(0, 3'd3, 16'h003C);
    rd(0, 3'd0, 16'h00A5);
    wr(0, 3'd1, 16'h0011);
    checkOutput("hold_after_write", dout[0], 16'h00A5);
    rd(0, 3'd1, 16'h0011);
    nop(0);
    checkOutput("hold_after_idle", dout[0], 16'h0011);

    // Access during sweep is rejected and leaves the cleared word alone.
    clr(0);
    checkOutput("clr_zeroes_dout", dout[0], 16'h0000);
    nop(0);
    bad(0, 1'b1, 3'd1, 16'h00FF);
    checkOutput("busy_during_sweep", busy_v[0], 1);
    nop(0);
    nop(0);
    checkOutput("busy_after_sweep", busy_v[0], 0);
    rd(0, 3'd1, 16'h0000);
    rd(0, 3'd3, 16'h0000);
    nop(0);

    // Restarting the sweep mid-way still covers every word.
    wr(0, 3'd2, 16'h0077);
    clr(0);
    nop(0);
    nop(0);
    clr(0);
    for (int k = 1; k <= 4; k++) begin
      nop(0);
      checkOutput($sformatf("restart_busy_e%0d", k), busy_v[0], (k < 4) ? 1 : 0);
    end
    rd(0, 3'd2, 16'h0000);
    nop(0);

    // Out-of-range addresses on the 3-deep instance.
    wr(1, 3'd0, 16'h0012);
    wr(1, 3'd1, 16'h0034);
    wr(1, 3'd2, 16'h0056);
    rd(1, 3'd2, 16'h0056);
    bad(1, 1'b0, 3'd3, 16'h0000);
    checkOutput("oor_rd_hold", dout[1], 16'h0056);
    bad(1, 1'b1, 3'd3, 16'h00EE);
    checkOutput("oor_wr_hold", dout[1], 16'h0056);
    applyStimulus(1, 1'b0, 1'b0, 1'b1, 3'd3, 16'h00EE, K_NONE, 16'h0);
    tick();
    rd(1, 3'd0, 16'h0012);
    rd(1, 3'd1, 16'h0034);
    rd(1, 3'd2, 16'h0056);
    nop(1);

    // Wider, deeper instance.
    wr(2, 3'd7, 16'hBEEF);
    rd(2, 3'd7, 16'hBEEF);
    wr(2, 3'd0, 16'h1234);
    rd(2, 3'd0, 16'h1234);
    rd(2, 3'd7, 16'hBEEF);
    nop(2);

    for (int k = 0; k < 3; k++) tick();
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("queue_drained%0d", i), exp_q[i].size(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
